// File: rtl/array_heap.sv
// array_heap: a pool of fixed-length arrays with per-array size, allocation and shifting insert/remove.
// Optional argument checking (errors 1, 2, 6) is enabled by defining ARRAY_HEAP_CHECK_EN.
module array_heap #(
    parameter int ADDRESS_BITS = 2,
    parameter int INDEX_BITS   = 2,
    parameter int DATA_BITS    = 12
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [7:0]              action,
    input  logic [ADDRESS_BITS-1:0] array,
    input  logic [INDEX_BITS-1:0]   index,
    input  logic [DATA_BITS-1:0]    in,
    output logic                    rsp_valid,
    output logic [DATA_BITS-1:0]    out,
    output logic [31:0]             error
);
    localparam int ARRAYS       = 2 ** ADDRESS_BITS;
    localparam int ARRAY_LENGTH = 2 ** INDEX_BITS;
    localparam int SW           = INDEX_BITS + 1;
    localparam int CW           = ADDRESS_BITS + 1;
    localparam logic [SW-1:0] LEN_S = SW'(ARRAY_LENGTH);

    localparam logic [7:0] ACT_RESET   = 8'd1;
    localparam logic [7:0] ACT_WRITE   = 8'd2;
    localparam logic [7:0] ACT_READ    = 8'd3;
    localparam logic [7:0] ACT_SIZE    = 8'd4;
    localparam logic [7:0] ACT_INC     = 8'd5;
    localparam logic [7:0] ACT_DEC     = 8'd6;
    localparam logic [7:0] ACT_LESS    = 8'd8;
    localparam logic [7:0] ACT_GREATER = 8'd9;
    localparam logic [7:0] ACT_UP      = 8'd10;
    localparam logic [7:0] ACT_DOWN    = 8'd11;
    localparam logic [7:0] ACT_PUSH    = 8'd14;
    localparam logic [7:0] ACT_POP     = 8'd15;
    localparam logic [7:0] ACT_RESIZE  = 8'd17;
    localparam logic [7:0] ACT_ALLOC   = 8'd18;
    localparam logic [7:0] ACT_FREE    = 8'd19;

    localparam logic [31:0] ERR_OK          = 32'd0;
    localparam logic [31:0] ERR_UNALLOC     = 32'd1;
    localparam logic [31:0] ERR_INDEX       = 32'd2;
    localparam logic [31:0] ERR_FULL        = 32'd3;
    localparam logic [31:0] ERR_EMPTY       = 32'd4;
    localparam logic [31:0] ERR_NOFREE      = 32'd5;
    localparam logic [31:0] ERR_DOUBLE_FREE = 32'd6;
    localparam logic [31:0] ERR_ACTION      = 32'd7;

    // Handshake: a request is taken on a rising edge with req_valid && req_ready;
    // req_ready is high only in ST_IDLE and rsp_valid is a one-cycle strobe.
    typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

    state_e                  state_q, state_d;
    logic [DATA_BITS-1:0]    mem_q [ARRAYS][ARRAY_LENGTH];
    logic [DATA_BITS-1:0]    mem_d [ARRAYS][ARRAY_LENGTH];
    logic [SW-1:0]           size_q [ARRAYS];
    logic [SW-1:0]           size_d [ARRAYS];
    logic [ARRAYS-1:0]       alloc_q, alloc_d;
    logic [ADDRESS_BITS-1:0] stack_q [ARRAYS];
    logic [ADDRESS_BITS-1:0] stack_d [ARRAYS];
    logic [CW-1:0]           sp_q, sp_d;
    logic [CW-1:0]           next_q, next_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_BITS-1:0]    out_q, out_d;
    logic [31:0]             error_q, error_d;
    logic                    up_q, up_d;
    logic [ADDRESS_BITS-1:0] sh_arr_q, sh_arr_d;
    logic [INDEX_BITS-1:0]   sh_idx_q, sh_idx_d;
    logic [INDEX_BITS-1:0]   ptr_q, ptr_d;
    logic [DATA_BITS-1:0]    sh_data_q, sh_data_d;

    logic [SW-1:0]           cur_size;
    logic [SW-1:0]           idx_ext;
    logic [SW-1:0]           less_cnt, greater_cnt;
    logic [31:0]             err;
    logic [ADDRESS_BITS-1:0] alloc_arr;
    logic                    known, uses_array, grows, shrinks;

    assign cur_size  = size_q[array];
    assign idx_ext   = {1'b0, index};
    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign out       = out_q;
    assign error     = error_q;

    always_comb begin
        less_cnt    = '0;
        greater_cnt = '0;
        for (int i = 0; i < ARRAY_LENGTH; i++) begin
            if (SW'(i) < cur_size) begin
                if (mem_q[array][i] < in) less_cnt = less_cnt + SW'(1);
                if (mem_q[array][i] > in) greater_cnt = greater_cnt + SW'(1);
            end
        end
    end

    always_comb begin
        known      = 1'b1;
        uses_array = 1'b1;
        grows      = 1'b0;
        shrinks    = 1'b0;
        case (action)
            ACT_RESET, ACT_ALLOC, ACT_FREE: uses_array = 1'b0;
            ACT_INC, ACT_UP, ACT_PUSH:      grows = 1'b1;
            ACT_DEC, ACT_DOWN, ACT_POP:     shrinks = 1'b1;
            ACT_WRITE, ACT_READ, ACT_SIZE, ACT_LESS, ACT_GREATER, ACT_RESIZE: ;
            default: begin
                known      = 1'b0;
                uses_array = 1'b0;
            end
        endcase
    end

    // Error priority: bad code, ownership, capacity, then index range.
    always_comb begin
        err = ERR_OK;
        if (!known) err = ERR_ACTION;
`ifdef ARRAY_HEAP_CHECK_EN
        else if (uses_array && !alloc_q[array]) err = ERR_UNALLOC;
        else if (action == ACT_FREE && !alloc_q[array]) err = ERR_DOUBLE_FREE;
`endif
        else if (grows && cur_size == LEN_S) err = ERR_FULL;
        else if (action == ACT_RESIZE && 32'(in) > 32'(ARRAY_LENGTH)) err = ERR_FULL;
        else if (shrinks && cur_size == '0) err = ERR_EMPTY;
        else if (action == ACT_ALLOC && sp_q == '0 && next_q == CW'(ARRAYS)) err = ERR_NOFREE;
`ifdef ARRAY_HEAP_CHECK_EN
        else if ((action == ACT_READ || action == ACT_DOWN) && idx_ext >= cur_size) err = ERR_INDEX;
        else if (action == ACT_UP && idx_ext > cur_size) err = ERR_INDEX;
`endif
    end

    always_comb begin
        state_d     = state_q;
        mem_d       = mem_q;
        size_d      = size_q;
        alloc_d     = alloc_q;
        stack_d     = stack_q;
        sp_d        = sp_q;
        next_d      = next_q;
        rsp_valid_d = 1'b0;
        out_d       = out_q;
        error_d     = error_q;
        up_d        = up_q;
        sh_arr_d    = sh_arr_q;
        sh_idx_d    = sh_idx_q;
        ptr_d       = ptr_q;
        sh_data_d   = sh_data_q;
        alloc_arr   = '0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    rsp_valid_d = 1'b1;
                    error_d     = err;
                    if (err == ERR_OK) begin
                        case (action)
                            ACT_RESET: begin
                                for (int a = 0; a < ARRAYS; a++) size_d[a] = '0;
                                alloc_d = '0;
                                sp_d    = '0;
                                next_d  = '0;
                                out_d   = '0;
                            end
                            ACT_WRITE: begin
                                mem_d[array][index] = in;
                                if (idx_ext >= cur_size) size_d[array] = idx_ext + SW'(1);
                                out_d = in;
                            end
                            ACT_READ:    out_d = mem_q[array][index];
                            ACT_SIZE:    out_d = DATA_BITS'(cur_size);
                            ACT_INC:     size_d[array] = cur_size + SW'(1);
                            ACT_DEC:     size_d[array] = cur_size - SW'(1);
                            ACT_LESS:    out_d = DATA_BITS'(less_cnt);
                            ACT_GREATER: out_d = DATA_BITS'(greater_cnt);
                            ACT_UP: begin
                                if (idx_ext < cur_size) begin
                                    state_d     = ST_SHIFT;
                                    rsp_valid_d = 1'b0;
                                    error_d     = error_q;
                                    up_d        = 1'b1;
                                    sh_arr_d    = array;
                                    sh_idx_d    = index;
                                    ptr_d       = INDEX_BITS'(cur_size - SW'(1));
                                    sh_data_d   = in;
                                end else begin
                                    mem_d[array][index] = in;
                                    size_d[array]       = cur_size + SW'(1);
                                    out_d               = in;
                                end
                            end
                            ACT_DOWN: begin
                                if (idx_ext + SW'(1) < cur_size) begin
                                    state_d     = ST_SHIFT;
                                    rsp_valid_d = 1'b0;
                                    error_d     = error_q;
                                    up_d        = 1'b0;
                                    sh_arr_d    = array;
                                    sh_idx_d    = index;
                                    ptr_d       = index;
                                    sh_data_d   = mem_q[array][index];
                                end else begin
                                    out_d         = mem_q[array][index];
                                    size_d[array] = cur_size - SW'(1);
                                end
                            end
                            ACT_PUSH: begin
                                mem_d[array][cur_size[INDEX_BITS-1:0]] = in;
                                size_d[array] = cur_size + SW'(1);
                                out_d         = in;
                            end
                            ACT_POP: begin
                                out_d         = mem_q[array][INDEX_BITS'(cur_size - SW'(1))];
                                size_d[array] = cur_size - SW'(1);
                            end
                            ACT_RESIZE: size_d[array] = SW'(in);
                            ACT_ALLOC: begin
                                // Recycled arrays take precedence over never-used ones.
                                if (sp_q != '0) begin
                                    alloc_arr = stack_q[ADDRESS_BITS'(sp_q - CW'(1))];
                                    sp_d      = sp_q - CW'(1);
                                end else begin
                                    alloc_arr = next_q[ADDRESS_BITS-1:0];
                                    next_d    = next_q + CW'(1);
                                end
                                alloc_d[alloc_arr] = 1'b1;
                                size_d[alloc_arr]  = '0;
                                out_d              = DATA_BITS'(alloc_arr);
                            end
                            ACT_FREE: begin
                                alloc_d[array] = 1'b0;
                                if (sp_q != CW'(ARRAYS)) begin
                                    stack_d[sp_q[ADDRESS_BITS-1:0]] = array;
                                    sp_d = sp_q + CW'(1);
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_SHIFT: begin
                if (up_q) begin
                    // Walk from the top down so each move reads an element not yet overwritten.
                    mem_d[sh_arr_q][ptr_q + INDEX_BITS'(1)] = mem_q[sh_arr_q][ptr_q];
                    if (ptr_q == sh_idx_q) begin
                        mem_d[sh_arr_q][sh_idx_q] = sh_data_q;
                        size_d[sh_arr_q] = size_q[sh_arr_q] + SW'(1);
                        out_d       = sh_data_q;
                        error_d     = ERR_OK;
                        rsp_valid_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        ptr_d = ptr_q - INDEX_BITS'(1);
                    end
                end else begin
                    mem_d[sh_arr_q][ptr_q] = mem_q[sh_arr_q][ptr_q + INDEX_BITS'(1)];
                    if (SW'(ptr_q) + SW'(2) == size_q[sh_arr_q]) begin
                        size_d[sh_arr_q] = size_q[sh_arr_q] - SW'(1);
                        out_d       = sh_data_q;
                        error_d     = ERR_OK;
                        rsp_valid_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        ptr_d = ptr_q + INDEX_BITS'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            for (int a = 0; a < ARRAYS; a++) begin
                size_q[a]  <= '0;
                stack_q[a] <= '0;
            end
            alloc_q     <= '0;
            sp_q        <= '0;
            next_q      <= '0;
            rsp_valid_q <= 1'b0;
            out_q       <= '0;
            error_q     <= '0;
            up_q        <= 1'b0;
            sh_arr_q    <= '0;
            sh_idx_q    <= '0;
            ptr_q       <= '0;
            sh_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            stack_q     <= stack_d;
            alloc_q     <= alloc_d;
            sp_q        <= sp_d;
            next_q      <= next_d;
            rsp_valid_q <= rsp_valid_d;
            out_q       <= out_d;
            error_q     <= error_d;
            up_q        <= up_d;
            sh_arr_q    <= sh_arr_d;
            sh_idx_q    <= sh_idx_d;
            ptr_q       <= ptr_d;
            sh_data_q   <= sh_data_d;
        end
    end

    // Element storage keeps its contents across reset; only bookkeeping is cleared.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_array_heap.sv
// Bench for array_heap: directed scenarios with literal expectations plus random requests
// checked against a behavioural model of the array pool.
module tb_array_heap;
  localparam int AB = 2;
  localparam int IB = 2;
  localparam int DB = 12;
  localparam int N_ARR = 1 << AB;
  localparam int LEN = 1 << IB;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [7:0] action = '0;
  logic [AB-1:0] array = '0;
  logic [IB-1:0] index = '0;
  logic [DB-1:0] in = '0;
  logic rsp_valid;
  logic [DB-1:0] out;
  logic [31:0] error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int rsp_count = 0;
  int last_out, last_err, last_lat;

  // behavioural model state
  int m_mem[N_ARR][LEN];
  int m_size[N_ARR];
  bit m_alloc[N_ARR];
  int m_free[$];
  int m_next;

  // scoreboard
  logic [31:0] exp_err_q[$];
  logic [DB-1:0] exp_out_q[$];
  bit exp_known_q[$];
  int exp_lat_q[$];
  int hold_out = 0;
  int hold_err = 0;
  bit hold_known = 1'b1;

  array_heap #(.ADDRESS_BITS(AB), .INDEX_BITS(IB), .DATA_BITS(DB)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .action(action), .array(array), .index(index), .in(in),
    .rsp_valid(rsp_valid), .out(out), .error(error)
  );

  // clock / reset block
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int model_error(input int act, input int a, input int i, input int d);
    bit known, uses;
    known = act inside {1, 2, 3, 4, 5, 6, 8, 9, 10, 11, 14, 15, 17, 18, 19};
    uses = act inside {2, 3, 4, 5, 6, 8, 9, 10, 11, 14, 15, 17};
    if (!known) return 7;
`ifdef ARRAY_HEAP_CHECK_EN
    if (uses && !m_alloc[a]) return 1;
    if (act == 19 && !m_alloc[a]) return 6;
`else
    if (uses && i < 0) return 99;
`endif
    if (act inside {5, 10, 14} && m_size[a] == LEN) return 3;
    if (act == 17 && d > LEN) return 3;
    if (act inside {6, 11, 15} && m_size[a] == 0) return 4;
    if (act == 18 && m_free.size() == 0 && m_next == N_ARR) return 5;
`ifdef ARRAY_HEAP_CHECK_EN
    if (act inside {3, 11} && i >= m_size[a]) return 2;
    if (act == 10 && i > m_size[a]) return 2;
`endif
    return 0;
  endfunction

  task automatic model_hw_reset();
    for (int a = 0; a < N_ARR; a++) begin
      m_size[a] = 0;
      m_alloc[a] = 1'b0;
    end
    m_free.delete();
    m_next = 0;
  endtask

  task automatic model_apply(input int act, input int a, input int i, input int d);
    int err, o, lat, cnt, n;
    bit kn;
    o = 0; lat = 1; kn = 1'b0;
    err = model_error(act, a, i, d);
    n = m_size[a];
    if (err == 0) begin
      kn = 1'b1;
      case (act)
        1: begin model_hw_reset(); o = 0; end
        2: begin m_mem[a][i] = d; if (i >= n) m_size[a] = i + 1; o = d; end
        3: o = m_mem[a][i];
        4: o = n;
        5: begin m_size[a] = n + 1; kn = 1'b0; end
        6: begin m_size[a] = n - 1; kn = 1'b0; end
        8, 9: begin
          cnt = 0;
          for (int j = 0; j < n; j++)
            if ((act == 8 && m_mem[a][j] < d) || (act == 9 && m_mem[a][j] > d)) cnt++;
          o = cnt;
        end
        10: begin
          if (i < n) begin
            lat = n - i + 1;
            for (int j = n - 1; j >= i; j--) m_mem[a][j + 1] = m_mem[a][j];
          end
          m_mem[a][i] = d; m_size[a] = n + 1; o = d;
        end
        11: begin
          o = m_mem[a][i];
          if (i < n) begin
            lat = n - i;
            for (int j = i; j < n - 1; j++) m_mem[a][j] = m_mem[a][j + 1];
          end
          m_size[a] = n - 1;
        end
        14: begin m_mem[a][n] = d; m_size[a] = n + 1; o = d; end
        15: begin o = m_mem[a][n - 1]; m_size[a] = n - 1; end
        17: begin m_size[a] = d; kn = 1'b0; end
        18: begin
          if (m_free.size() > 0) o = m_free.pop_back();
          else begin o = m_next; m_next++; end
          m_alloc[o] = 1'b1; m_size[o] = 0;
        end
        19: begin
          m_alloc[a] = 1'b0; kn = 1'b0;
          if (m_free.size() < N_ARR) m_free.push_back(a);
        end
        default: kn = 1'b0;
      endcase
    end
    exp_err_q.push_back(32'(err));
    exp_out_q.push_back(DB'(o));
    exp_known_q.push_back(kn);
    exp_lat_q.push_back(lat);
  endtask

  // compare process
  always @(negedge clock) begin
    if (reset) begin
      if (rsp_valid) begin
        if (exp_err_q.size() == 0) begin
          check("unexpected_rsp", 1, 0);
        end else begin
          logic [31:0] e_err;
          logic [DB-1:0] e_out;
          bit e_kn;
          int e_lat;
          e_err = exp_err_q.pop_front();
          e_out = exp_out_q.pop_front();
          e_kn = exp_known_q.pop_front();
          e_lat = exp_lat_q.pop_front();
          check("rsp_error", int'(error), int'(e_err));
          if (e_kn) check("rsp_out", int'(out), int'(e_out));
          check("rsp_latency", cyc - accept_cyc + 1, e_lat);
          check("rsp_ready", int'(req_ready), 1);
          hold_err = int'(e_err);
          hold_known = e_kn;
          hold_out = int'(e_out);
          last_out = int'(out);
          last_err = int'(error);
          last_lat = cyc - accept_cyc + 1;
          rsp_count++;
        end
      end else begin
        check("hold_error", int'(error), hold_err);
        if (hold_known) check("hold_out", int'(out), hold_out);
      end
    end
  end

  // driver task: one request, waits for its response
  task automatic do_req(input int act, input int a, input int i, input int d);
    int start;
    model_apply(act, a, i, d);
    @(negedge clock);
    check("req_ready_idle", int'(req_ready), 1);
    req_valid = 1'b1;
    action = 8'(act);
    array = AB'(a);
    index = IB'(i);
    in = DB'(d);
    @(posedge clock);
    accept_cyc = cyc + 1;
    #1 req_valid = 1'b0;
    start = rsp_count;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      #1;
      if (rsp_count != start) break;
      check("busy_not_ready", int'(req_ready), 0);
    end
    if (rsp_count == start) begin
      check("rsp_timeout", 0, 1);
      exp_err_q.delete(); exp_out_q.delete(); exp_known_q.delete(); exp_lat_q.delete();
    end
  endtask

  initial begin
    int r, act;
    int bad_tab[6] = '{0, 7, 12, 16, 20, 255};
    int act_tab[14] = '{2, 3, 4, 5, 6, 8, 9, 10, 11, 14, 15, 17, 18, 19};
    model_hw_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    check("reset_rsp_valid", int'(rsp_valid), 0);
    check("reset_out", int'(out), 0);
    check("reset_error", int'(error), 0);
    #1 reset = 1'b1;
    @(negedge clock);
    #1;
    check("post_reset_ready", int'(req_ready), 1);
    check("post_reset_rsp_valid", int'(rsp_valid), 0);

    // give every element a known value, then clear bookkeeping
    for (int a = 0; a < N_ARR; a++) do_req(18, 0, 0, 0);
    for (int a = 0; a < N_ARR; a++)
      for (int i = 0; i < LEN; i++) do_req(2, a, i, $urandom_range(0, 40));
    do_req(1, 0, 0, 0);
    check("reset_action_out", last_out, 0);

    do_req(18, 0, 0, 0); check("alloc_first", last_out, 0); check("alloc_first_err", last_err, 0);
    do_req(18, 0, 0, 0); check("alloc_second", last_out, 1);

    do_req(14, 0, 0, 5); do_req(14, 0, 0, 7); do_req(14, 0, 0, 9);
    do_req(10, 0, 1, 3);
    check("up_out", last_out, 3); check("up_latency", last_lat, 3);
    do_req(3, 0, 0, 0); check("up_elem0", last_out, 5);
    do_req(3, 0, 1, 0); check("up_elem1", last_out, 3);
    do_req(3, 0, 2, 0); check("up_elem2", last_out, 7);
    do_req(3, 0, 3, 0); check("up_elem3", last_out, 9);
    do_req(4, 0, 0, 0); check("up_size", last_out, 4);

    do_req(14, 0, 0, 11); check("push_full_err", last_err, 3);
    do_req(15, 0, 0, 0); check("pop1", last_out, 9);
    do_req(15, 0, 0, 0); check("pop2", last_out, 7);
    do_req(15, 0, 0, 0); check("pop3", last_out, 3);
    do_req(15, 0, 0, 0); check("pop4", last_out, 5);
    do_req(15, 0, 0, 0); check("pop_empty_err", last_err, 4);

    do_req(19, 1, 0, 0);
    do_req(18, 0, 0, 0); check("realloc_out", last_out, 1);
    do_req(19, 1, 0, 0);
    do_req(19, 1, 0, 0);
`ifdef ARRAY_HEAP_CHECK_EN
    check("double_free_err", last_err, 6);
`else
    check("double_free_err", last_err, 0);
`endif

    do_req(2, 0, 0, 10); do_req(2, 0, 1, 20); do_req(2, 0, 2, 30);
    do_req(9, 0, 0, 15); check("greater_15", last_out, 2);
    do_req(8, 0, 0, 15); check("less_15", last_out, 1);
    do_req(11, 0, 0, 0);
    check("down_out", last_out, 10); check("down_latency", last_lat, 3);
    do_req(3, 0, 0, 0); check("down_elem0", last_out, 20);
    do_req(3, 0, 1, 0); check("down_elem1", last_out, 30);
    do_req(4, 0, 0, 0); check("down_size", last_out, 2);

    // random requests against the model
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 2) act = 1;
      else if (r < 6) act = bad_tab[$urandom_range(0, 5)];
      else act = act_tab[$urandom_range(0, 13)];
      if (act == 17) do_req(act, $urandom_range(0, N_ARR - 1), 0, $urandom_range(0, LEN + 2));
      else do_req(act, $urandom_range(0, N_ARR - 1), $urandom_range(0, LEN - 1), $urandom_range(0, 40));
    end

    // reset asserted in the middle of an Up shift
    do_req(1, 0, 0, 0);
    do_req(18, 0, 0, 0);
    do_req(14, 0, 0, 1); do_req(14, 0, 0, 2); do_req(14, 0, 0, 3);
    @(negedge clock);
    action = 8'd10; array = '0; index = '0; in = DB'(9); req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    exp_err_q.delete(); exp_out_q.delete(); exp_known_q.delete(); exp_lat_q.delete();
    model_hw_reset();
    hold_out = 0; hold_err = 0; hold_known = 1'b1;
    @(negedge clock);
    #1;
    check("abort_rsp_valid", int'(rsp_valid), 0);
    check("abort_out", int'(out), 0);
    check("abort_error", int'(error), 0);
    @(negedge clock);
    #2 reset = 1'b1;
    repeat (6) @(negedge clock);
    #1;
    check("abort_ready_after", int'(req_ready), 1);
    do_req(4, 0, 0, 0);
    check("abort_size", last_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
